ex_muldiv: RTL and testbench

//   Iterative multiply/divide unit beside the EX-stage ALU. Computes the HI/LO pair for

---
 rtl/ex_muldiv_if.sv | 29 ++
 rtl/ex_muldiv.sv | 169 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Handshake between the EX stage and the iterative multiply/divide unit.
// The EX stage drives the master side; ex_muldiv uses the slave side.
interface ex_muldiv_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb;
   logic [XLEN-1:0] hi_in;
   logic [XLEN-1:0] lo_in;
   logic            stall_req;
   logic            busy;
   logic            we_hilo;
   logic [XLEN-1:0] hi_o;
   logic [XLEN-1:0] lo_o;
   logic            div_by_zero;

   modport master (
      output flush, start, op, opa, opb, hi_in, lo_in,
      input  stall_req, busy, we_hilo, hi_o, lo_o, div_by_zero
   );

   modport slave (
      input  flush, start, op, opa, opb, hi_in, lo_in,
      output stall_req, busy, we_hilo, hi_o, lo_o, div_by_zero
   );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit beside the EX-stage ALU: shift-add multiply,
// restoring divide and multiply-accumulate, retiring STEP result bits per BUSY cycle.
module ex_muldiv #(
   parameter int XLEN = 32,
   parameter int STEP = 1
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);
   localparam int            ITERS   = XLEN / STEP;
   localparam int            CW      = $clog2(ITERS + 1);
   localparam logic [CW-1:0] ITERS_C = CW'(ITERS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     count;
   logic              is_div_q;
   logic              is_sub_q;
   logic              neg_res_q;
   logic              neg_rem_q;
   logic [XLEN-1:0]   mag_q;
   logic [XLEN:0]     work_hi;
   logic [XLEN-1:0]   work_lo;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;
   logic              dbz_q;

   // Op decode: op[2] accumulates, op[1] selects divide (or subtract when accumulating),
   // op[0] selects the unsigned variant.
   logic            in_div;
   logic            in_acc;
   logic            in_sub;
   logic            in_signed;
   logic            in_dbz;
   logic            sign_a;
   logic            sign_b;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;

   always_comb begin
      in_div    = ~bus.op[2] & bus.op[1];
      in_acc    = bus.op[2];
      in_sub    = bus.op[2] & bus.op[1];
      in_signed = ~bus.op[0];
      in_dbz    = in_div & (bus.opb == '0);
      sign_a    = in_signed & bus.opa[XLEN-1];
      sign_b    = in_signed & bus.opb[XLEN-1];
      mag_a     = sign_a ? -bus.opa : bus.opa;
      mag_b     = sign_b ? -bus.opb : bus.opb;
   end

   // One BUSY cycle of work: STEP iterations of either restoring divide
   // (work_hi = partial remainder, work_lo = dividend shifting into quotient) or
   // shift-add multiply (work_hi = partial sum with carry, work_lo = multiplier).
   logic [XLEN:0]   step_hi;
   logic [XLEN-1:0] step_lo;
   logic [XLEN:0]   t_hi;

   always_comb begin
      step_hi = work_hi;
      step_lo = work_lo;
      t_hi    = '0;
      for (int i = 0; i < STEP; i++) begin
         if (is_div_q) begin
            t_hi    = {step_hi[XLEN-1:0], step_lo[XLEN-1]};
            step_lo = {step_lo[XLEN-2:0], 1'b0};
            if (t_hi >= {1'b0, mag_q}) begin
               t_hi       = t_hi - {1'b0, mag_q};
               step_lo[0] = 1'b1;
            end
            step_hi = t_hi;
         end else begin
            t_hi    = step_lo[0] ? step_hi + {1'b0, mag_q} : step_hi;
            step_lo = {t_hi[0], step_lo[XLEN-1:1]};
            step_hi = {1'b0, t_hi[XLEN:1]};
         end
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [2*XLEN-1:0] mac;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;

   always_comb begin
      prod   = {step_hi[XLEN-1:0], step_lo};
      prod_s = neg_res_q ? -prod : prod;
      mac    = is_sub_q ? acc_q - prod_s : acc_q + prod_s;
      quo    = neg_res_q ? -step_lo : step_lo;
      rem    = neg_rem_q ? -step_hi[XLEN-1:0] : step_hi[XLEN-1:0];
   end

   // acc_q is zero for plain MULT/MULTU so the same adder produces every product result;
   // the final sign fix and accumulate happen on the last BUSY cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         is_div_q  <= 1'b0;
         is_sub_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         mag_q     <= '0;
         work_hi   <= '0;
         work_lo   <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
      end else if (bus.flush) begin
         state <= IDLE;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  is_div_q  <= in_div;
                  is_sub_q  <= in_sub;
                  neg_res_q <= sign_a ^ sign_b;
                  neg_rem_q <= sign_a;
                  mag_q     <= in_div ? mag_b : mag_a;
                  work_hi   <= '0;
                  work_lo   <= in_div ? mag_a : mag_b;
                  acc_q     <= in_acc ? {bus.hi_in, bus.lo_in} : '0;
                  if (in_dbz) begin
                     state <= DONE;
                     count <= '0;
                     hi_q  <= bus.opa;
                     lo_q  <= '1;
                     dbz_q <= 1'b1;
                  end else begin
                     state <= BUSY;
                     count <= ITERS_C;
                     dbz_q <= 1'b0;
                  end
               end
            end
            BUSY: begin
               work_hi <= step_hi;
               work_lo <= step_lo;
               count   <= count - CW'(1);
               if (count == CW'(1)) begin
                  state <= DONE;
                  hi_q  <= is_div_q ? rem : mac[2*XLEN-1:XLEN];
                  lo_q  <= is_div_q ? quo : mac[XLEN-1:0];
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.stall_req   = ((state == IDLE) & bus.start & ~bus.flush) | (state == BUSY);
   assign bus.busy        = (state != IDLE);
   assign bus.we_hilo     = (state == DONE) & ~bus.flush;
   assign bus.div_by_zero = (state == DONE) & dbz_q & ~bus.flush;
   assign bus.hi_o        = hi_q;
   assign bus.lo_o        = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: a STEP=1 and a STEP=4 instance, an arithmetic
// reference model checked every cycle, and directed vectors with literal expectations.
module tb_ex_muldiv;
   localparam int NDUT = 2;

   localparam logic [2:0] MULT  = 3'd0;
   localparam logic [2:0] MULTU = 3'd1;
   localparam logic [2:0] DIV   = 3'd2;
   localparam logic [2:0] DIVU  = 3'd3;
   localparam logic [2:0] MADD  = 3'd4;
   localparam logic [2:0] MADDU = 3'd5;
   localparam logic [2:0] MSUB  = 3'd6;
   localparam logic [2:0] MSUBU = 3'd7;

   logic   clk = 1'b0;
   logic   rst;
   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;

   logic        flush_v [NDUT];
   logic        start_v [NDUT];
   logic [2:0]  op_v    [NDUT];
   logic [31:0] opa_v   [NDUT];
   logic [31:0] opb_v   [NDUT];
   logic [31:0] hin_v   [NDUT];
   logic [31:0] lin_v   [NDUT];
   logic        stall_w [NDUT];
   logic        busy_w  [NDUT];
   logic        we_w    [NDUT];
   logic        dbz_w   [NDUT];
   logic [31:0] hi_w    [NDUT];
   logic [31:0] lo_w    [NDUT];

   ex_muldiv_if #(.XLEN(32)) bus1 ();
   ex_muldiv_if #(.XLEN(32)) bus4 ();

   assign bus1.flush = flush_v[0];
   assign bus1.start = start_v[0];
   assign bus1.op    = op_v[0];
   assign bus1.opa   = opa_v[0];
   assign bus1.opb   = opb_v[0];
   assign bus1.hi_in = hin_v[0];
   assign bus1.lo_in = lin_v[0];
   assign stall_w[0] = bus1.stall_req;
   assign busy_w[0]  = bus1.busy;
   assign we_w[0]    = bus1.we_hilo;
   assign dbz_w[0]   = bus1.div_by_zero;
   assign hi_w[0]    = bus1.hi_o;
   assign lo_w[0]    = bus1.lo_o;

   assign bus4.flush = flush_v[1];
   assign bus4.start = start_v[1];
   assign bus4.op    = op_v[1];
   assign bus4.opa   = opa_v[1];
   assign bus4.opb   = opb_v[1];
   assign bus4.hi_in = hin_v[1];
   assign bus4.lo_in = lin_v[1];
   assign stall_w[1] = bus4.stall_req;
   assign busy_w[1]  = bus4.busy;
   assign we_w[1]    = bus4.we_hilo;
   assign dbz_w[1]   = bus4.div_by_zero;
   assign hi_w[1]    = bus4.hi_o;
   assign lo_w[1]    = bus4.lo_o;

   ex_muldiv #(.XLEN(32), .STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   ex_muldiv #(.XLEN(32), .STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int iterOf(input int d);
      return (d == 0) ? 32 : 8;
   endfunction

   // Reference result {div_by_zero, hi, lo} straight from the arithmetic definition.
   function automatic logic [64:0] modelOp(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hin,
                                           input logic [31:0] lin);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] sprod;
      logic [63:0] uprod;
      logic [63:0] acc;
      logic [64:0] res;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      sprod = sa * sb;
      uprod = {32'd0, a} * {32'd0, b};
      acc   = {hin, lin};
      res   = '0;
      case (op)
         MULT:  res = {1'b0, sprod};
         MULTU: res = {1'b0, uprod};
         DIV, DIVU: begin
            if (b == 32'd0) begin
               res = {1'b1, a, 32'hFFFF_FFFF};
            end else if (op == DIV) begin
               q   = sa / sb;
               r   = sa % sb;
               res = {1'b0, r[31:0], q[31:0]};
            end else begin
               res = {1'b0, a % b, a / b};
            end
         end
         MADD:  res = {1'b0, acc + sprod};
         MADDU: res = {1'b0, acc + uprod};
         MSUB:  res = {1'b0, acc - sprod};
         default: res = {1'b0, acc - uprod};
      endcase
      return res;
   endfunction

   task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Per-cycle model state: one pending job per instance, due at a fixed cycle.
   bit          pend    [NDUT];
   longint      done_at [NDUT];
   logic [64:0] job     [NDUT];
   logic [31:0] com_hi  [NDUT];
   logic [31:0] com_lo  [NDUT];
   bit          known   [NDUT];

   task automatic modelCycle(input int d);
      bit in_done;
      bit in_busy;
      if (rst) begin
         pend[d]   = 1'b0;
         com_hi[d] = '0;
         com_lo[d] = '0;
         known[d]  = 1'b1;
      end else begin
         in_done = pend[d] && (cyc == done_at[d]);
         in_busy = pend[d] && !in_done;
         if (in_done) begin
            com_hi[d] = job[d][63:32];
            com_lo[d] = job[d][31:0];
            known[d]  = !flush_v[d];
         end
         checkOutput($sformatf("dut%0d we_hilo", d), 65'(we_w[d]), 65'(in_done && !flush_v[d]));
         checkOutput($sformatf("dut%0d div_by_zero", d), 65'(dbz_w[d]),
                     65'(in_done && !flush_v[d] && job[d][64]));
         checkOutput($sformatf("dut%0d busy", d), 65'(busy_w[d]), 65'(pend[d]));
         checkOutput($sformatf("dut%0d stall_req", d), 65'(stall_w[d]),
                     65'((!pend[d] && start_v[d] && !flush_v[d]) || in_busy));
         if (known[d]) begin
            checkOutput($sformatf("dut%0d hi_o", d), 65'(hi_w[d]), 65'(com_hi[d]));
            checkOutput($sformatf("dut%0d lo_o", d), 65'(lo_w[d]), 65'(com_lo[d]));
         end
         if (flush_v[d] || in_done) begin
            pend[d] = 1'b0;
         end else if (!pend[d] && start_v[d]) begin
            pend[d]    = 1'b1;
            job[d]     = modelOp(op_v[d], opa_v[d], opb_v[d], hin_v[d], lin_v[d]);
            done_at[d] = cyc + (job[d][64] ? 1 : iterOf(d) + 1);
         end
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) modelCycle(d);
   end

   task automatic applyStimulus(input int d, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hin,
                                input logic [31:0] lin);
      @(posedge clk);
      #1;
      start_v[d] = 1'b1;
      op_v[d]    = op;
      opa_v[d]   = a;
      opb_v[d]   = b;
      hin_v[d]   = hin;
      lin_v[d]   = lin;
   endtask

   // Issues one op and returns at the negedge of its DONE cycle.
   task automatic runOp(input int d, input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] hin,
                        input logic [31:0] lin, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
      int lat;
      int stalls;
      bit seen;
      lat    = 0;
      stalls = 0;
      seen   = 1'b0;
      applyStimulus(d, op, a, b, hin, lin);
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (k == 0) checkOutput($sformatf("%s busy at start", tag), 65'(busy_w[d]), 65'(0));
         if (we_w[d]) begin
            seen = 1'b1;
         end else begin
            lat++;
            if (stall_w[d]) stalls++;
            @(posedge clk);
            #1;
            start_v[d] = 1'b0;
         end
      end
      checkOutput($sformatf("%s done seen", tag), 65'(seen), 65'(1));
      checkOutput($sformatf("%s latency", tag), 65'(lat), 65'(exp_lat));
      checkOutput($sformatf("%s stall cycles", tag), 65'(stalls), 65'(exp_lat));
      checkOutput($sformatf("%s hi_o", tag), 65'(hi_w[d]), 65'(exp_hi));
      checkOutput($sformatf("%s lo_o", tag), 65'(lo_w[d]), 65'(exp_lo));
      checkOutput($sformatf("%s div_by_zero", tag), 65'(dbz_w[d]), 65'(exp_dbz));
      checkOutput($sformatf("%s stall in done", tag), 65'(stall_w[d]), 65'(0));
   endtask

   task automatic expectIdle(input int d, input string tag);
      @(negedge clk);
      checkOutput($sformatf("%s busy after done", tag), 65'(busy_w[d]), 65'(0));
      checkOutput($sformatf("%s we_hilo after done", tag), 65'(we_w[d]), 65'(0));
   endtask

   task automatic pinModel();
      checkOutput("model MULT", modelOp(MULT, 32'hFFFF_FFFD, 32'd5, 0, 0),
                  {1'b0, 64'hFFFF_FFFF_FFFF_FFF1});
      checkOutput("model DIV", modelOp(DIV, 32'hFFFF_FFF9, 32'd2, 0, 0),
                  {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
      checkOutput("model DIV minint", modelOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0),
                  {1'b0, 64'h0000_0000_8000_0000});
      checkOutput("model DIVU by zero", modelOp(DIVU, 32'd7, 32'd0, 0, 0),
                  {1'b1, 64'h0000_0007_FFFF_FFFF});
      checkOutput("model MADDU", modelOp(MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF),
                  {1'b0, 64'h0000_0001_0000_0000});
      checkOutput("model MSUB", modelOp(MSUB, 32'd2, 32'd3, 0, 0),
                  {1'b0, 64'hFFFF_FFFF_FFFF_FFFA});
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int wes;
      rst = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         flush_v[d] = 1'b0;
         start_v[d] = 1'b0;
         op_v[d]    = '0;
         opa_v[d]   = '0;
         opb_v[d]   = '0;
         hin_v[d]   = '0;
         lin_v[d]   = '0;
      end
      pinModel();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         checkOutput($sformatf("reset dut%0d hi_o", d), 65'(hi_w[d]), 65'(0));
         checkOutput($sformatf("reset dut%0d lo_o", d), 65'(lo_w[d]), 65'(0));
         checkOutput($sformatf("reset dut%0d busy", d), 65'(busy_w[d]), 65'(0));
         checkOutput($sformatf("reset dut%0d we_hilo", d), 65'(we_w[d]), 65'(0));
      end

      runOp(0, "MULT -3*5", MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      expectIdle(0, "MULT -3*5");
      runOp(0, "DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      runOp(0, "DIVU 7/0", DIVU, 32'd7, 32'd0, 0, 0, 1, 32'd7, 32'hFFFF_FFFF, 1'b1);
      runOp(0, "DIV minint/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, 32'd0, 32'h8000_0000, 1'b0);
      runOp(0, "DIV -5/0", DIV, 32'hFFFF_FFFB, 32'd0, 0, 0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
      runOp(0, "MADDU", MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 33, 32'd1, 32'd0, 1'b0);
      runOp(0, "MSUB", MSUB, 32'd2, 32'd3, 32'd0, 32'd0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
      runOp(0, "MADD", MADD, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, 33, 32'd0, 32'd4, 1'b0);
      runOp(0, "MSUBU", MSUBU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 33, 32'hFFFF_FFFF, 32'd2, 1'b0);
      runOp(0, "MULT minint^2", MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 33, 32'h4000_0000, 32'd0, 1'b0);
      runOp(0, "DIVU big", DIVU, 32'hFFFF_FFFF, 32'h10, 0, 0, 33, 32'hF, 32'h0FFF_FFFF, 1'b0);
      runOp(0, "DIV 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 33, 32'd1, 32'hFFFF_FFFD, 1'b0);

      // Squash in the tenth BUSY cycle: no write, outputs keep the DIV 7/-2 result.
      applyStimulus(0, MULTU, 32'd1234, 32'd5678, 0, 0);
      @(negedge clk);
      repeat (10) begin
         @(posedge clk);
         #1;
         start_v[0] = 1'b0;
      end
      flush_v[0] = 1'b1;
      @(negedge clk);
      checkOutput("flush busy in flush cycle", 65'(busy_w[0]), 65'(1));
      checkOutput("flush we_hilo", 65'(we_w[0]), 65'(0));
      @(posedge clk);
      #1;
      flush_v[0] = 1'b0;
      @(negedge clk);
      checkOutput("flush busy next", 65'(busy_w[0]), 65'(0));
      checkOutput("flush hi_o kept", 65'(hi_w[0]), 65'(1));
      checkOutput("flush lo_o kept", 65'(lo_w[0]), 65'(32'hFFFF_FFFD));
      wes = 0;
      repeat (40) begin
         @(negedge clk);
         if (we_w[0]) wes++;
      end
      checkOutput("flush no late write", 65'(wes), 65'(0));

      applyStimulus(0, MULT, 32'd3, 32'd3, 0, 0);
      repeat (6) begin
         @(posedge clk);
         #1;
         start_v[0] = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst mid-busy hi_o", 65'(hi_w[0]), 65'(0));
      checkOutput("rst mid-busy lo_o", 65'(lo_w[0]), 65'(0));
      checkOutput("rst mid-busy busy", 65'(busy_w[0]), 65'(0));
      checkOutput("rst mid-busy stall_req", 65'(stall_w[0]), 65'(0));
      checkOutput("rst mid-busy we_hilo", 65'(we_w[0]), 65'(0));
      checkOutput("rst mid-busy div_by_zero", 65'(dbz_w[0]), 65'(0));

      applyStimulus(0, DIVU, 32'd9, 32'd0, 0, 0);
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      flush_v[0] = 1'b1;
      @(negedge clk);
      checkOutput("flush in done we_hilo", 65'(we_w[0]), 65'(0));
      checkOutput("flush in done div_by_zero", 65'(dbz_w[0]), 65'(0));
      @(posedge clk);
      #1;
      flush_v[0] = 1'b0;
      @(negedge clk);
      checkOutput("flush in done busy next", 65'(busy_w[0]), 65'(0));

      @(posedge clk);
      #1;
      start_v[0] = 1'b1;
      flush_v[0] = 1'b1;
      op_v[0]    = MULT;
      @(negedge clk);
      checkOutput("start with flush stall_req", 65'(stall_w[0]), 65'(0));
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      flush_v[0] = 1'b0;
      @(negedge clk);
      checkOutput("start with flush busy", 65'(busy_w[0]), 65'(0));

      runOp(0, "DIVU again", DIVU, 32'hFFFF_FFFF, 32'h10, 0, 0, 33, 32'hF, 32'h0FFF_FFFF, 1'b0);

      runOp(1, "S4 MULTU", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 9, 32'hFFFF_FFFE, 32'd1, 1'b0);
      runOp(1, "S4 DIVU", DIVU, 32'h100, 32'd7, 0, 0, 9, 32'd4, 32'h24, 1'b0);
      runOp(1, "S4 DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 9, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      runOp(1, "S4 MSUBU", MSUBU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 9, 32'hFFFF_FFFF, 32'd2, 1'b0);
      expectIdle(1, "S4 MSUBU");

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
